// File: rtl/shk_merge.sv
// shk_merge: eight shake initiators (s_shk_0..7) share one shake responder
// (m_shk_0). A round-robin arbiter grants one initiator at a time; its request
// is forwarded to the master port and the reply is routed back only to it.
//
// Handshake: an initiator holds wvalid high with smosi/dmosi stable until it
// samples wready = 1; the transfer completes on the cycle where wvalid and
// wready are both 1, and smiso/dmiso are valid on that same cycle.
//
// Ports:
//   i_sys_clk, i_sys_rst          clock, asynchronous active-high reset
//   s_shk_n_wvalid/smosi/dmosi    request from initiator n (n = 0..7)
//   s_shk_n_wready/smiso/dmiso    completion and response to initiator n
//   m_shk_0_wvalid/smosi/dmosi    merged request to the responder
//   m_shk_0_wready/smiso/dmiso    reply from the responder
//   o_grant_id                    index of the current or last granted initiator
//   o_timeout                     one-cycle pulse, high in the DONE cycle that
//                                 follows a forced (timed-out) completion
//   o_dbg_state                   FSM state (0 IDLE, 1 BUSY, 2 DONE)
module shk_merge #(
  parameter int WD_SHK_SYNC = 16,
  parameter int WD_SHK_DLAY = 15,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                   i_sys_clk,
  input  logic                   i_sys_rst,
  input  logic                   s_shk_0_wvalid,
  input  logic [WD_SHK_SYNC-1:0] s_shk_0_smosi,
  input  logic [WD_SHK_DLAY-1:0] s_shk_0_dmosi,
  output logic                   s_shk_0_wready,
  output logic [WD_SHK_SYNC-1:0] s_shk_0_smiso,
  output logic [WD_SHK_DLAY-1:0] s_shk_0_dmiso,
  input  logic                   s_shk_1_wvalid,
  input  logic [WD_SHK_SYNC-1:0] s_shk_1_smosi,
  input  logic [WD_SHK_DLAY-1:0] s_shk_1_dmosi,
  output logic                   s_shk_1_wready,
  output logic [WD_SHK_SYNC-1:0] s_shk_1_smiso,
  output logic [WD_SHK_DLAY-1:0] s_shk_1_dmiso,
  input  logic                   s_shk_2_wvalid,
  input  logic [WD_SHK_SYNC-1:0] s_shk_2_smosi,
  input  logic [WD_SHK_DLAY-1:0] s_shk_2_dmosi,
  output logic                   s_shk_2_wready,
  output logic [WD_SHK_SYNC-1:0] s_shk_2_smiso,
  output logic [WD_SHK_DLAY-1:0] s_shk_2_dmiso,
  input  logic                   s_shk_3_wvalid,
  input  logic [WD_SHK_SYNC-1:0] s_shk_3_smosi,
  input  logic [WD_SHK_DLAY-1:0] s_shk_3_dmosi,
  output logic                   s_shk_3_wready,
  output logic [WD_SHK_SYNC-1:0] s_shk_3_smiso,
  output logic [WD_SHK_DLAY-1:0] s_shk_3_dmiso,
  input  logic                   s_shk_4_wvalid,
  input  logic [WD_SHK_SYNC-1:0] s_shk_4_smosi,
  input  logic [WD_SHK_DLAY-1:0] s_shk_4_dmosi,
  output logic                   s_shk_4_wready,
  output logic [WD_SHK_SYNC-1:0] s_shk_4_smiso,
  output logic [WD_SHK_DLAY-1:0] s_shk_4_dmiso,
  input  logic                   s_shk_5_wvalid,
  input  logic [WD_SHK_SYNC-1:0] s_shk_5_smosi,
  input  logic [WD_SHK_DLAY-1:0] s_shk_5_dmosi,
  output logic                   s_shk_5_wready,
  output logic [WD_SHK_SYNC-1:0] s_shk_5_smiso,
  output logic [WD_SHK_DLAY-1:0] s_shk_5_dmiso,
  input  logic                   s_shk_6_wvalid,
  input  logic [WD_SHK_SYNC-1:0] s_shk_6_smosi,
  input  logic [WD_SHK_DLAY-1:0] s_shk_6_dmosi,
  output logic                   s_shk_6_wready,
  output logic [WD_SHK_SYNC-1:0] s_shk_6_smiso,
  output logic [WD_SHK_DLAY-1:0] s_shk_6_dmiso,
  input  logic                   s_shk_7_wvalid,
  input  logic [WD_SHK_SYNC-1:0] s_shk_7_smosi,
  input  logic [WD_SHK_DLAY-1:0] s_shk_7_dmosi,
  output logic                   s_shk_7_wready,
  output logic [WD_SHK_SYNC-1:0] s_shk_7_smiso,
  output logic [WD_SHK_DLAY-1:0] s_shk_7_dmiso,
  output logic                   m_shk_0_wvalid,
  output logic [WD_SHK_SYNC-1:0] m_shk_0_smosi,
  output logic [WD_SHK_DLAY-1:0] m_shk_0_dmosi,
  input  logic                   m_shk_0_wready,
  input  logic [WD_SHK_SYNC-1:0] m_shk_0_smiso,
  input  logic [WD_SHK_DLAY-1:0] m_shk_0_dmiso,
  output logic [2:0]             o_grant_id,
  output logic                   o_timeout,
  output logic [1:0]             o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [15:0] TCNT_LAST = 16'(TIMEOUT_CYC - 1);

  // Per-initiator views as arrays so the arbiter and router can index by grant.
  logic [7:0]             s_wvalid;
  logic [WD_SHK_SYNC-1:0] s_smosi [8];
  logic [WD_SHK_DLAY-1:0] s_dmosi [8];
  logic [7:0]             s_wready;
  logic [WD_SHK_SYNC-1:0] s_smiso [8];
  logic [WD_SHK_DLAY-1:0] s_dmiso [8];

  assign s_wvalid = {s_shk_7_wvalid, s_shk_6_wvalid, s_shk_5_wvalid, s_shk_4_wvalid,
                     s_shk_3_wvalid, s_shk_2_wvalid, s_shk_1_wvalid, s_shk_0_wvalid};
  assign s_smosi[0] = s_shk_0_smosi;
  assign s_smosi[1] = s_shk_1_smosi;
  assign s_smosi[2] = s_shk_2_smosi;
  assign s_smosi[3] = s_shk_3_smosi;
  assign s_smosi[4] = s_shk_4_smosi;
  assign s_smosi[5] = s_shk_5_smosi;
  assign s_smosi[6] = s_shk_6_smosi;
  assign s_smosi[7] = s_shk_7_smosi;
  assign s_dmosi[0] = s_shk_0_dmosi;
  assign s_dmosi[1] = s_shk_1_dmosi;
  assign s_dmosi[2] = s_shk_2_dmosi;
  assign s_dmosi[3] = s_shk_3_dmosi;
  assign s_dmosi[4] = s_shk_4_dmosi;
  assign s_dmosi[5] = s_shk_5_dmosi;
  assign s_dmosi[6] = s_shk_6_dmosi;
  assign s_dmosi[7] = s_shk_7_dmosi;

  state_t      state_q, state_d;
  logic [2:0]  grant_q, grant_d;
  logic [2:0]  last_q, last_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic        timeout_q, timeout_d;

  // Round-robin pick: first requester at last+1, last+2, ... wrapping mod 8,
  // so the previous winner is considered last.
  logic [2:0] pick;
  logic [2:0] idx;
  logic       req_any;

  always_comb begin
    pick    = last_q;
    idx     = last_q;
    req_any = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      idx = last_q + 3'(i);
      if (!req_any && s_wvalid[idx]) begin
        pick    = idx;
        req_any = 1'b1;
      end
    end
  end

  logic busy;
  logic g_wvalid;
  logic at_limit;
  logic timeout_hit;
  logic complete;

  // At the timeout cycle the master request is withdrawn, so the responder
  // cannot complete concurrently with the forced completion.
  always_comb begin
    busy        = (state_q == ST_BUSY);
    g_wvalid    = s_wvalid[grant_q];
    at_limit    = busy && (tcnt_q == TCNT_LAST);
    timeout_hit = at_limit && g_wvalid;
    complete    = busy && g_wvalid && !at_limit && m_shk_0_wready;
  end

  always_comb begin
    m_shk_0_wvalid = busy && g_wvalid && !at_limit;
    m_shk_0_smosi  = busy ? s_smosi[grant_q] : '0;
    m_shk_0_dmosi  = busy ? s_dmosi[grant_q] : '0;
  end

  always_comb begin
    for (int n = 0; n < 8; n++) begin
      s_wready[n] = 1'b0;
      s_smiso[n]  = '0;
      s_dmiso[n]  = '0;
    end
    if (busy) begin
      s_wready[grant_q] = complete || timeout_hit;
      s_smiso[grant_q]  = timeout_hit ? '1 : m_shk_0_smiso;
      s_dmiso[grant_q]  = timeout_hit ? '0 : m_shk_0_dmiso;
    end
  end

  assign s_shk_0_wready = s_wready[0];
  assign s_shk_1_wready = s_wready[1];
  assign s_shk_2_wready = s_wready[2];
  assign s_shk_3_wready = s_wready[3];
  assign s_shk_4_wready = s_wready[4];
  assign s_shk_5_wready = s_wready[5];
  assign s_shk_6_wready = s_wready[6];
  assign s_shk_7_wready = s_wready[7];
  assign s_shk_0_smiso  = s_smiso[0];
  assign s_shk_1_smiso  = s_smiso[1];
  assign s_shk_2_smiso  = s_smiso[2];
  assign s_shk_3_smiso  = s_smiso[3];
  assign s_shk_4_smiso  = s_smiso[4];
  assign s_shk_5_smiso  = s_smiso[5];
  assign s_shk_6_smiso  = s_smiso[6];
  assign s_shk_7_smiso  = s_smiso[7];
  assign s_shk_0_dmiso  = s_dmiso[0];
  assign s_shk_1_dmiso  = s_dmiso[1];
  assign s_shk_2_dmiso  = s_dmiso[2];
  assign s_shk_3_dmiso  = s_dmiso[3];
  assign s_shk_4_dmiso  = s_dmiso[4];
  assign s_shk_5_dmiso  = s_dmiso[5];
  assign s_shk_6_dmiso  = s_dmiso[6];
  assign s_shk_7_dmiso  = s_dmiso[7];

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    tcnt_d    = tcnt_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          grant_d = pick;
          last_d  = pick;
          tcnt_d  = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (complete) begin
          state_d = ST_DONE;
        end else if (!g_wvalid) begin
          // Initiator withdrew: abandon without completing it.
          state_d = ST_IDLE;
        end else if (timeout_hit) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 16'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= 3'd0;
      last_q    <= 3'd7;
      tcnt_q    <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      tcnt_q    <= tcnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_grant_id  = grant_q;
  assign o_timeout   = timeout_q;
  assign o_dbg_state = state_q;

endmodule

// File: doc/shk_merge.md
# shk_merge

Shake-bus N:1 merge with round-robin arbitration and response timeout. It is the reverse of the shake fan-out: eight shake initiators (slaver ports `s_shk_0..7`) share one downstream shake responder (master port `m_shk_0`). One transaction owns the master port at a time. The response (`wready`, `smiso`, `dmiso`) is routed back only to the granted initiator. It sits between register or command sources and a single shared shake target.

## Interface
- `WD_SHK_SYNC`, default 16: width of `smosi`/`smiso`.
- `WD_SHK_DLAY`, default 15: width of `dmosi`/`dmiso`.
- `TIMEOUT_CYC`, default 1023: cycles in BUSY without `m_shk_0_wready` before forced completion; range 1..65535.

Ports:
- `i_sys_clk`  in  1  system clock; all logic on the rising edge.
- `i_sys_rst`  in  1  asynchronous, active-high reset.
- `s_shk_n_wvalid`  in  1  initiator n request, n = 0..7.
- `s_shk_n_smosi`  in  WD_SHK_SYNC  initiator n sync word.
- `s_shk_n_dmosi`  in  WD_SHK_DLAY  initiator n data word.
- `s_shk_n_wready`  out  1  completion to initiator n.
- `s_shk_n_smiso`  out  WD_SHK_SYNC  response sync word to initiator n.
- `s_shk_n_dmiso`  out  WD_SHK_DLAY  response data word to initiator n.
- `m_shk_0_wvalid`, `m_shk_0_smosi`, `m_shk_0_dmosi`  out  1 / WD_SHK_SYNC / WD_SHK_DLAY  merged request.
- `m_shk_0_wready`, `m_shk_0_smiso`, `m_shk_0_dmiso`  in  1 / WD_SHK_SYNC / WD_SHK_DLAY  responder reply.
- `o_grant_id`  out  3  registered index of the current or last granted initiator.
- `o_timeout`  out  1  one-cycle pulse on forced completion.

## Operation
- Protocol:
  - An initiator holds `wvalid` high with `smosi`/`dmosi` stable until it samples `wready` = 1.
  - A transaction completes on the cycle where `wvalid` and `wready` are both 1.
  - `smiso`/`dmiso` are valid on that cycle.
- Registers:
  - `state` ∈ {IDLE, BUSY, DONE}.
  - `grant[2:0]`.
  - `last[2:0]`.
  - `tcnt[15:0]`.
- IDLE:
  - If any `s_shk_n_wvalid` = 1, select the first requester searching `last+1, last+2, …` modulo 8.
  - Register the selection into `grant` and `last`, clear `tcnt`, and move to BUSY.
  - If there is no request, stay in IDLE.
- BUSY:
  - `m_shk_0_*` mosi outputs are combinational copies of initiator `grant`.
  - `m_shk_0_wready`, `smiso` and `dmiso` are routed combinationally to `s_shk_grant`.
  - On `m_shk_0_wready & m_shk_0_wvalid`, move to DONE.
  - If `s_shk_grant_wvalid` drops before completion (abort), move to IDLE with no `wready` issued.
  - Otherwise `tcnt` increments each cycle.
- Timeout: when `tcnt == TIMEOUT_CYC-1` in BUSY with no completion:
  - Force `s_shk_grant_wready` = 1 with `smiso` all ones and `dmiso` = 0 for that cycle.
  - Drive `m_shk_0_wvalid` = 0 on that cycle.
  - Pulse `o_timeout` and move to DONE.
- DONE:
  - All `m_shk_0` outputs are 0 and all `s_shk_n_wready` are 0.
  - Unconditionally move to IDLE. This one-cycle bubble lets the initiator drop `wvalid`.
- Non-granted initiators, and all initiators outside BUSY, see `wready` = 0, `smiso` = 0, `dmiso` = 0.
- Outside BUSY, `m_shk_0_wvalid`, `smosi` and `dmosi` are 0.
- Reset values:
  - state IDLE, `grant` = 0, `last` = 7 (port 0 has first priority), `tcnt` = 0.
  - `o_grant_id` = 0, `o_timeout` = 0.
  - All outputs 0.
- Reset mid-transaction: master `wvalid` drops asynchronously and no `wready` is returned. After release, arbitration restarts from port 0.
- Simultaneous requests are resolved by round-robin only; there is no fixed priority other than the reset pointer.

## Timing
- Request sampled in IDLE at cycle t → `grant` registered at edge t+1 → `m_shk_0_wvalid` = 1 during cycle t+1.
- Responder `wready` in cycle t+k → `s_shk_grant_wready` = 1 in the same cycle t+k (zero latency).
- DONE in cycle t+k+1, IDLE in cycle t+k+2. The earliest next grant is visible in cycle t+k+3.
- Minimum spacing between master-port transactions: 3 cycles.
- Timeout: `wready` is forced in the BUSY cycle where `tcnt` = TIMEOUT_CYC-1, i.e. TIMEOUT_CYC cycles after the grant.
- `o_grant_id` changes only at the IDLE→BUSY edge.

## Test plan
- Single request: port 3 raises wvalid with smosi=0x0008, dmosi=0x1234; responder replies smiso=0x00A5 two cycles later → `m_shk_0_smosi`=0x0008 from cycle t+1; port 3 sees wready=1 with smiso=0x00A5; `o_grant_id`=3; all other ports see 0.
- Round-robin: ports 0, 2 and 7 request simultaneously after reset, and the responder acks each in 1 cycle → grants in order 0, 2, 7. Port 0 re-requesting after its ack is served after 7.
- Timeout: TIMEOUT_CYC=8; port 5 requests and the responder never acks → on the 8th BUSY cycle port 5 gets wready=1, smiso=0xFFFF, dmiso=0, and `o_timeout` pulses once; the next grant starts after DONE.
- Abort: port 1 drops wvalid during BUSY before any ack → master wvalid=0 next cycle, no wready to port 1, and a pending port 4 is granted.
- Reset mid-BUSY: assert `i_sys_rst` while port 6 is granted → all outputs 0 immediately. After release, with ports 6 and 0 requesting, port 0 is granted first.
- Back-to-back: port 2 requests continuously and the responder acks immediately → master transactions are spaced exactly 3 cycles apart, and wready is never 1 in DONE.
